// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/grant/response bus.
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master(output req, addr, input gnt, rvalid, rdata);
    modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, credit-limited imem requests, in-order instruction queue
// and redirect handling that drops in-flight wrong-path responses.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    instr_fetch_if.master        imem,
    output logic [31:0]          if_instr_o,
    output logic [31:0]          if_pc_o,
    output logic                 if_valid_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   tag_q   [FIFO_DEPTH];
    logic [31:0]   q_pc_q  [FIFO_DEPTH];
    logic [31:0]   q_instr_q [FIFO_DEPTH];
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, twp_q, twp_d, trp_q, trp_d;
    logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic          fire, rsp, keep, pop;

    // Credit counts queued plus in-flight (including to-be-dropped) fetches.
    assign imem.req   = rst_n && !redirect_i && (cnt_q + out_q) < CW'(FIFO_DEPTH);
    assign imem.addr  = pc_q;
    assign if_valid_o = cnt_q != '0 && !redirect_i;
    assign if_instr_o = if_valid_o ? q_instr_q[rp_q] : '0;
    assign if_pc_o    = if_valid_o ? q_pc_q[rp_q] : '0;

    assign fire = imem.req && imem.gnt;
    assign rsp  = imem.rvalid && out_q != '0;
    assign keep = rsp && drop_q == '0 && !redirect_i;
    assign pop  = if_valid_o && !stall_i;

    always_comb begin
        pc_d   = redirect_i ? redirect_pc_i : fire ? pc_q + 32'd4 : pc_q;
        twp_d  = fire ? twp_q + AW'(1) : twp_q;
        trp_d  = rsp ? trp_q + AW'(1) : trp_q;
        out_d  = out_q + CW'(fire) - CW'(rsp);
        drop_d = redirect_i ? out_q - CW'(rsp) : (rsp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        wp_d   = redirect_i ? '0 : keep ? wp_q + AW'(1) : wp_q;
        rp_d   = redirect_i ? '0 : pop ? rp_q + AW'(1) : rp_q;
        cnt_d  = redirect_i ? '0 : cnt_q + CW'(keep) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            wp_q   <= '0;
            rp_q   <= '0;
            twp_q  <= '0;
            trp_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            twp_q  <= twp_d;
            trp_q  <= trp_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the counters.
    always_ff @(posedge clk) begin
        if (fire) tag_q[twp_q] <= pc_q;
        if (keep) begin
            q_pc_q[wp_q]    <= tag_q[trp_q];
            q_instr_q[wp_q] <= imem.rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized imem/stall/redirect stimulus checked every cycle
// against an epoch-tagged queue model of the fetch stage.
module tb_instr_fetch;
    localparam int DEPTH = 2;

    typedef struct { logic [31:0] addr; int ready; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    logic        clk, rst_n, stall_i, redirect_i, if_valid_o;
    logic [31:0] redirect_pc_i, if_instr_o, if_pc_o;
    instr_fetch_if imem();

    instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem(imem.master),
        .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .if_valid_o(if_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, epoch = 0;
    int p_gnt, p_stall, p_redir, lat_min, lat_max;
    logic [31:0] fpc, held;
    req_t pend[$];
    ent_t mq[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic er, ev;
        logic [31:0] ep, ei;
        req_t r;
        @(posedge clk);
        #1;
        stall_i       = $urandom_range(99) < p_stall;
        redirect_i    = $urandom_range(99) < p_redir;
        redirect_pc_i = (p_redir == 100) ? 32'h400 : ($urandom & 32'hFFFF_FFFC);
        imem.gnt      = $urandom_range(99) < p_gnt;
        imem.rvalid   = pend.size() > 0 && pend[0].ready <= cyc;
        imem.rdata    = imem.rvalid ? mem(pend[0].addr) : $urandom;
        @(negedge clk);
        ev = mq.size() != 0 && !redirect_i;
        er = !redirect_i && (mq.size() + pend.size()) < DEPTH;
        ep = ev ? mq[0].pc : 32'd0;
        ei = ev ? mq[0].instr : 32'd0;
        chk("req", imem.req, er);
        chk("addr", imem.addr, fpc);
        chk("valid", if_valid_o, ev);
        chk("pc", if_pc_o, ep);
        chk("instr", if_instr_o, ei);
        if (ev && !stall_i) void'(mq.pop_front());
        if (imem.rvalid) begin
            r = pend.pop_front();
            if (!redirect_i && r.epoch == epoch) mq.push_back('{r.addr, mem(r.addr)});
        end
        if (er && imem.gnt) begin
            pend.push_back('{fpc, cyc + $urandom_range(lat_max, lat_min), epoch});
            fpc += 32'd4;
        end
        if (redirect_i) begin
            mq.delete();
            fpc = redirect_pc_i;
            epoch++;
        end
        cyc++;
    endtask

    task automatic zero_inputs();
        stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        imem.gnt = 0; imem.rvalid = 0; imem.rdata = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, imem.req, 0);
        chk({tag, "_addr"}, imem.addr, 0);
        chk({tag, "_valid"}, if_valid_o, 0);
        chk({tag, "_pc"}, if_pc_o, 0);
        chk({tag, "_instr"}, if_instr_o, 0);
    endtask

    initial begin
        rst_n = 0;
        zero_inputs();
        fpc = 0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1;
        // Streaming with single-cycle memory
        p_gnt = 100; p_stall = 0; p_redir = 0; lat_min = 1; lat_max = 1;
        cycle();
        chk("first_req", imem.req, 1);
        chk("first_addr", imem.addr, 32'h0);
        chk("first_early_valid", if_valid_o, 0);
        cycle();
        cycle();
        chk("first_valid", if_valid_o, 1);
        chk("first_pc", if_pc_o, 32'h0);
        chk("first_instr", if_instr_o, 32'hBEEF_1234);
        cycle();
        chk("second_pc", if_pc_o, 32'h4);
        repeat (6) cycle();
        // Stall until credit is exhausted
        p_stall = 100;
        repeat (3) cycle();
        held = if_pc_o;
        repeat (2) cycle();
        chk("stall_pc", if_pc_o, held);
        chk("stall_valid", if_valid_o, 1);
        chk("stall_req", imem.req, 0);
        p_stall = 0;
        repeat (10) cycle();
        // Redirect with responses in flight
        lat_min = 3; lat_max = 3;
        repeat (4) cycle();
        p_redir = 100;
        cycle();
        chk("redir_cycle_valid", if_valid_o, 0);
        chk("redir_cycle_req", imem.req, 0);
        p_redir = 0;
        for (int i = 0; i < 20 && !if_valid_o; i++) cycle();
        chk("redir_valid", if_valid_o, 1);
        chk("redir_pc", if_pc_o, 32'h400);
        chk("redir_instr", if_instr_o, 32'hBAEF_1234);
        // Random traffic
        p_gnt = 60; p_stall = 25; p_redir = 3; lat_min = 1; lat_max = 4;
        repeat (3000) cycle();
        // Asynchronous reset with a full queue and fetches outstanding
        p_gnt = 100; p_stall = 100; p_redir = 0; lat_min = 1; lat_max = 6;
        repeat (6) cycle();
        rst_n = 0;
        #1;
        chk_zero("midreset");
        pend.delete();
        mq.delete();
        fpc = 0;
        epoch++;
        zero_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        p_stall = 0; lat_max = 2;
        cycle();
        chk("resume_addr", imem.addr, 32'h0);
        chk("resume_req", imem.req, 1);
        repeat (10) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
